// File: rtl/soc_sysid_checker.sv
// soc_sysid_checker
// Avalon-MM read master that fetches the system ID (word 0) and the build
// timestamp (word 1) from the system-ID slave. It compares both words with
// compile-time constants and publishes pass/fail flags and the captured words.
// A run starts automatically after reset, or on a start pulse while idle/done.
// Optional feature, enabled by defining SOC_SYSID_CHECK_RETRY_EN: a failed or
// timed-out run is retried up to 3 times, and a retry_count port is added.
module soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1649824396,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
`ifdef SOC_SYSID_CHECK_RETRY_EN
  ,
  output logic [1:0]  retry_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_LAT_ID, S_RD_TS, S_LAT_TS, S_DONE
  } state_e;

  localparam bit          HAS_LAT  = (READ_LATENCY > 0);
  localparam logic [15:0] LAT_LAST = HAS_LAT ? 16'(READ_LATENCY - 1) : 16'd0;
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        auto_go_q, auto_go_d;
  logic        avm_address_q, avm_address_d;
  logic        avm_read_q, avm_read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] lat_cnt_q, lat_cnt_d;
`ifdef SOC_SYSID_CHECK_RETRY_EN
  logic [1:0]  retry_cnt_q, retry_cnt_d;
`endif

  // Run-control events decoded in the next-state process.
  logic launch, capture, finish, retry_go;
  logic fin_timeout, fin_id_ok, fin_ts_ok;

  // State register and registered bus/status outputs, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      auto_go_q     <= 1'b1;
      avm_address_q <= 1'b0;
      avm_read_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      // NOTE: the captured words are reset too, so a reset mid-run never leaves a partial capture visible.
      id_value_q    <= '0;
      ts_value_q    <= '0;
      stall_cnt_q   <= '0;
      lat_cnt_q     <= '0;
`ifdef SOC_SYSID_CHECK_RETRY_EN
      retry_cnt_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every flop load pre-edge values, independent of statement order.
      state_q       <= state_d;
      auto_go_q     <= auto_go_d;
      avm_address_q <= avm_address_d;
      avm_read_q    <= avm_read_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_q     <= timeout_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      stall_cnt_q   <= stall_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
`ifdef SOC_SYSID_CHECK_RETRY_EN
      retry_cnt_q   <= retry_cnt_d;
`endif
    end
  end

  // Next-state and next-output logic: read sequencing, stall timeout, capture and compare.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d       = state_q;
    auto_go_d     = auto_go_q;
    avm_address_d = avm_address_q;
    avm_read_d    = avm_read_q;
    busy_d        = busy_q;
    done_d        = done_q;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_d     = timeout_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    stall_cnt_d   = stall_cnt_q;
    lat_cnt_d     = lat_cnt_q;
`ifdef SOC_SYSID_CHECK_RETRY_EN
    retry_cnt_d   = retry_cnt_q;
`endif
    launch        = 1'b0;
    capture       = 1'b0;
    finish        = 1'b0;
    retry_go      = 1'b0;
    fin_timeout   = 1'b0;
    fin_id_ok     = 1'b0;
    fin_ts_ok     = 1'b0;

    unique case (state_q)
      S_IDLE: launch = auto_go_q | start;
      S_DONE: launch = start;
      S_RD_ID, S_RD_TS: begin
        if (!avm_waitrequest) begin
          stall_cnt_d = '0;
          if (HAS_LAT) begin
            avm_read_d = 1'b0;
            lat_cnt_d  = '0;
            state_d    = (state_q == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
          end else begin
            capture = 1'b1;
          end
        end else if (stall_cnt_q == TO_LAST) begin
          stall_cnt_d = '0;
          finish      = 1'b1;
          fin_timeout = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end
      S_LAT_ID, S_LAT_TS: begin
        if (lat_cnt_q == LAT_LAST) capture = 1'b1;
        else                       lat_cnt_d = lat_cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      if (state_q == S_RD_ID || state_q == S_LAT_ID) begin
        id_value_d    = avm_readdata;
        state_d       = S_RD_TS;
        avm_read_d    = 1'b1;
        avm_address_d = 1'b1;
      end else begin
        ts_value_d = avm_readdata;
        finish     = 1'b1;
        fin_id_ok  = (id_value_q == EXPECTED_ID);
        fin_ts_ok  = (avm_readdata == EXPECTED_TS);
      end
    end

`ifdef SOC_SYSID_CHECK_RETRY_EN
    if (finish && !(fin_id_ok && fin_ts_ok) && retry_cnt_q != 2'd3) begin
      retry_go    = 1'b1;
      retry_cnt_d = retry_cnt_q + 2'd1;
    end
    if (launch) retry_cnt_d = '0;
`endif

    if (finish) begin
      if (retry_go) begin
        state_d       = S_RD_ID;
        avm_read_d    = 1'b1;
        avm_address_d = 1'b0;
      end else begin
        state_d    = S_DONE;
        avm_read_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        timeout_d  = fin_timeout;
        id_ok_d    = fin_id_ok;
        ts_ok_d    = fin_ts_ok;
      end
    end

    if (launch) begin
      state_d       = S_RD_ID;
      auto_go_d     = 1'b0;
      avm_read_d    = 1'b1;
      avm_address_d = 1'b0;
      busy_d        = 1'b1;
      done_d        = 1'b0;
      timeout_d     = 1'b0;
      id_ok_d       = 1'b0;
      ts_ok_d       = 1'b0;
      stall_cnt_d   = '0;
    end
  end

  // Output mapping: all ports come straight from registers.
  always_comb begin
    avm_address = avm_address_q;
    avm_read    = avm_read_q;
    busy        = busy_q;
    done        = done_q;
    id_ok       = id_ok_q;
    ts_ok       = ts_ok_q;
    timeout     = timeout_q;
    id_value    = id_value_q;
    ts_value    = ts_value_q;
`ifdef SOC_SYSID_CHECK_RETRY_EN
    retry_count = retry_cnt_q;
`endif
  end

endmodule

// File: tb/tb_soc_sysid_checker.sv
// tb_soc_sysid_checker
// Two checker instances (READ_LATENCY 0 and 2, TIMEOUT_CYCLES 8) share one
// reset/start and one run configuration. Each has its own behavioural slave.
// Expected results per run are predicted from the run configuration and queued.
// A monitor pops and compares them when done rises.
module tb_soc_sysid_checker;

  localparam int          N      = 2;
  localparam int          TO     = 8;
  localparam int          LAT1   = 2;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1649824396;

  typedef struct packed {
    int          done_edge;
    logic [31:0] id;
    logic [31:0] ts;
    logic        id_ok;
    logic        ts_ok;
    logic        to;
  } exp_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        avm_address     [N];
  logic        avm_read        [N];
  logic        avm_waitrequest [N];
  logic [31:0] avm_readdata    [N];
  logic        busy            [N];
  logic        done            [N];
  logic        id_ok           [N];
  logic        ts_ok           [N];
  logic        timeout         [N];
  logic [31:0] id_value        [N];
  logic [31:0] ts_value        [N];
`ifdef SOC_SYSID_CHECK_RETRY_EN
  logic [1:0]  retry_count     [N];
`endif

  exp_t exp_q [N][$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Run configuration: slave words, stalls per read, stuck mode
  // (0 none, 1 word-0 read never accepted, 2 word-1 read never accepted).
  logic [31:0] cfg_word  [2];
  int          cfg_stall [2];
  int          cfg_stuck = 0;
  logic [31:0] model_id  = '0;
  logic [31:0] model_ts  = '0;

  // Slave bookkeeping, per instance.
  logic prev_read  [N] = '{default: 1'b0};
  logic prev_wr    [N] = '{default: 1'b0};
  logic prev_addr  [N] = '{default: 1'b0};
  int   stall_seen [N] = '{default: 0};
  int   lat_left   [N] = '{default: 0};
  logic pend_addr  [N] = '{default: 1'b0};
  logic done_prev  [N] = '{default: 1'b0};

  soc_sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
                      .READ_LATENCY(0), .TIMEOUT_CYCLES(TO)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address[0]), .avm_read(avm_read[0]),
    .avm_waitrequest(avm_waitrequest[0]), .avm_readdata(avm_readdata[0]),
    .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
    .timeout(timeout[0]), .id_value(id_value[0]), .ts_value(ts_value[0])
`ifdef SOC_SYSID_CHECK_RETRY_EN
    , .retry_count(retry_count[0])
`endif
  );

  soc_sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
                      .READ_LATENCY(LAT1), .TIMEOUT_CYCLES(TO)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address[1]), .avm_read(avm_read[1]),
    .avm_waitrequest(avm_waitrequest[1]), .avm_readdata(avm_readdata[1]),
    .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
    .timeout(timeout[1]), .id_value(id_value[1]), .ts_value(ts_value[1])
`ifdef SOC_SYSID_CHECK_RETRY_EN
    , .retry_count(retry_count[1])
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : LAT1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural slave: counts stalled edges per read, supplies data
  // READ_LATENCY edges after acceptance, and checks bus rules on the way.
  always @(negedge clock) begin : slave
    logic acc, stalled, wr, stuck_now;
    for (int i = 0; i < N; i++) begin
      acc     = reset_n && prev_read[i] && !prev_wr[i];
      stalled = reset_n && prev_read[i] && prev_wr[i];
      if (lat_left[i] > 0) lat_left[i]--;
      if (!reset_n || !prev_read[i] || acc) stall_seen[i] = 0;
      else if (stalled)                     stall_seen[i]++;
      if (stalled && avm_read[i] === 1'b1)
        check($sformatf("dut%0d address stable while read held", i),
              32'(avm_address[i]), 32'(prev_addr[i]));
      if (!reset_n) lat_left[i] = 0;
      else if (acc && lat_of(i) > 0) begin
        lat_left[i]  = lat_of(i);
        pend_addr[i] = prev_addr[i];
      end
      if (reset_n && lat_left[i] > 0)
        check($sformatf("dut%0d avm_read during latency wait", i), 32'(avm_read[i]), 32'd0);
      stuck_now = (cfg_stuck == 1 && avm_address[i] === 1'b0) ||
                  (cfg_stuck == 2 && avm_address[i] === 1'b1);
      wr = stuck_now || (avm_read[i] === 1'b1 && stall_seen[i] < cfg_stall[avm_address[i] === 1'b1]);
      avm_waitrequest[i] = wr;
      if (lat_of(i) == 0)
        avm_readdata[i] = (avm_read[i] === 1'b1 && !wr) ? cfg_word[avm_address[i] === 1'b1] : $urandom;
      else
        avm_readdata[i] = (lat_left[i] == 1) ? cfg_word[pend_addr[i]] : $urandom;
      prev_read[i] = (avm_read[i] === 1'b1);
      prev_wr[i]   = wr;
      prev_addr[i] = (avm_address[i] === 1'b1);
    end
  end

  // Monitor: on every rising done, compare against the oldest queued prediction.
  always @(negedge clock) begin : monitor
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (reset_n && done[i] === 1'b1 && !done_prev[i]) begin
        if (exp_q[i].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL dut%0d unexpected done at edge %0d, no run pending", i, cyc);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("dut%0d done edge", i), 32'(cyc), 32'(e.done_edge));
          check($sformatf("dut%0d id_value", i), id_value[i], e.id);
          check($sformatf("dut%0d ts_value", i), ts_value[i], e.ts);
          check($sformatf("dut%0d id_ok", i), 32'(id_ok[i]), 32'(e.id_ok));
          check($sformatf("dut%0d ts_ok", i), 32'(ts_ok[i]), 32'(e.ts_ok));
          check($sformatf("dut%0d timeout", i), 32'(timeout[i]), 32'(e.to));
          check($sformatf("dut%0d busy at done", i), 32'(busy[i]), 32'd0);
          check($sformatf("dut%0d avm_read at done", i), 32'(avm_read[i]), 32'd0);
        end
      end
      done_prev[i] = reset_n && (done[i] === 1'b1);
    end
  end

  // Reference model: a run leaving IDLE on edge L ends after one launch edge,
  // then (stalls + 1 + latency) edges per read, or TIMEOUT stalled edges on a stuck read.
  task automatic launch();
    exp_t e;
    int   l, len_id, len_ts;
    l = cyc + 1;
    for (int i = 0; i < N; i++) begin
      len_id  = cfg_stall[0] + 1 + lat_of(i);
      len_ts  = cfg_stall[1] + 1 + lat_of(i);
      e.id    = model_id;
      e.ts    = model_ts;
      e.id_ok = 1'b0;
      e.ts_ok = 1'b0;
      e.to    = 1'b0;
      case (cfg_stuck)
        1: begin
          e.done_edge = l + TO;
          e.to        = 1'b1;
        end
        2: begin
          e.done_edge = l + len_id + TO;
          e.id        = cfg_word[0];
          e.to        = 1'b1;
        end
        default: begin
          e.done_edge = l + len_id + len_ts;
          e.id        = cfg_word[0];
          e.ts        = cfg_word[1];
          e.id_ok     = (cfg_word[0] == EXP_ID);
          e.ts_ok     = (cfg_word[1] == EXP_TS);
        end
      endcase
      exp_q[i].push_back(e);
    end
    if (cfg_stuck != 1) model_id = cfg_word[0];
    if (cfg_stuck == 0) model_ts = cfg_word[1];
  endtask

  task automatic set_cfg(input logic [31:0] w0, input logic [31:0] w1,
                         input int s0, input int s1, input int stuck);
    cfg_word[0]  = w0;
    cfg_word[1]  = w1;
    cfg_stall[0] = s0;
    cfg_stall[1] = s1;
    cfg_stuck    = stuck;
  endtask

  task automatic start_run();
    @(negedge clock);
    start = 1'b1;
    launch();
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("dut%0d busy after launch", i), 32'(busy[i]), 32'd1);
      check($sformatf("dut%0d done after launch", i), 32'(done[i]), 32'd0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      n_errors++;
      $display("FAIL run completion: no done within %0d cycles", n);
      exp_q[0].delete();
      exp_q[1].delete();
    end
    @(negedge clock);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("dut%0d %s avm_read", i, tag), 32'(avm_read[i]), 32'd0);
      check($sformatf("dut%0d %s busy", i, tag), 32'(busy[i]), 32'd0);
      check($sformatf("dut%0d %s done", i, tag), 32'(done[i]), 32'd0);
      check($sformatf("dut%0d %s id_ok", i, tag), 32'(id_ok[i]), 32'd0);
      check($sformatf("dut%0d %s timeout", i, tag), 32'(timeout[i]), 32'd0);
      check($sformatf("dut%0d %s id_value", i, tag), id_value[i], 32'd0);
      check($sformatf("dut%0d %s ts_value", i, tag), ts_value[i], 32'd0);
    end
  endtask

  initial begin
    int r;
    set_cfg(EXP_ID, EXP_TS, 0, 0, 0);
    repeat (3) @(negedge clock);
    check_reset_state("reset");

    // Automatic run after reset release, zero-wait slave, correct words.
    @(negedge clock);
    reset_n = 1'b1;
    launch();
    wait_idle();

    // Wrong ID word.
    set_cfg(32'h1234_5678, EXP_TS, 0, 0, 0);
    start_run();
    wait_idle();

    // Five stalls per read, no timeout.
    set_cfg(EXP_ID, EXP_TS, 5, 5, 0);
    start_run();
    wait_idle();

    // Stall boundary: TO-1 stalls still accepted.
    set_cfg(EXP_ID, 32'hDEAD_BEEF, TO - 1, TO - 1, 0);
    start_run();
    wait_idle();

    // Stuck ID read, then stuck timestamp read (ID captured, old ts retained).
    set_cfg(32'hAAAA_0001, EXP_TS, 0, 0, 1);
    start_run();
    wait_idle();
    set_cfg(32'h0000_0000, EXP_TS, 2, 0, 2);
    start_run();
    wait_idle();

    // Start while busy is ignored; done then stays high; start after done reruns.
    set_cfg(EXP_ID, EXP_TS, 5, 5, 0);
    start_run();
    repeat (4) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clock);
    for (int i = 0; i < N; i++)
      check($sformatf("dut%0d done held", i), 32'(done[i]), 32'd1);
    start_run();
    wait_idle();

    // Reset mid-transaction: read drops, captures cleared, automatic rerun.
    set_cfg($urandom, $urandom, 4, 4, 0);
    start_run();
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    model_id = '0;
    model_ts = '0;
    repeat (2) @(negedge clock);
    check_reset_state("mid-run reset");
    set_cfg(EXP_ID, EXP_TS, 1, 3, 0);
    @(negedge clock);
    reset_n = 1'b1;
    launch();
    wait_idle();

    // Randomized runs.
    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(0, 9);
      set_cfg($urandom_range(0, 1) ? EXP_ID : $urandom,
              $urandom_range(0, 1) ? EXP_TS : $urandom,
              $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
              (r == 0) ? 1 : (r == 1) ? 2 : 0);
      start_run();
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
